// File: rtl/kv_pkg.sv
// Shared encodings for the key/value path: request ops, response status,
// and default key/value widths (also used by the key extractor).
package kv_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int VAL_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_PUT   = 2'b00,
    OP_GET   = 2'b01,
    OP_DEL   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_NOT_FOUND = 2'b01,
    ST_FULL      = 2'b10,
    ST_BAD_OP    = 2'b11
  } status_e;

endpackage

// File: rtl/kv_table.sv
// Small associative key/value table, linear search one entry per clock.
// Optional KV_TABLE_CLEAR_EN enables op 11 (CLEAR); otherwise it answers BAD_OP.
module kv_table
  import kv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KEY_W = KEY_W_DEF,
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [KEY_W-1:0]           req_key,
  input  logic [VAL_W-1:0]           req_val,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [VAL_W-1:0]           rsp_val,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t              state, state_nx;
  op_e                 op_q;
  logic [KEY_W-1:0]    key_q;
  logic [VAL_W-1:0]    val_q;
  logic [IW-1:0]       idx, free_idx, put_idx;
  logic                free_found;
  logic [DEPTH-1:0]    valid;
  logic [KEY_W-1:0]    keys [DEPTH];
  logic [VAL_W-1:0]    vals [DEPTH];
  logic [CW-1:0]       count_q;
  status_e             status_q;
  logic [VAL_W-1:0]    rsp_val_q;
  logic                accept, scan_hit, scan_end, slot_free, put_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // One shared comparator on the scanned entry; PUT targets the hit, else the lowest free slot.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    put_write = 1'b0;
    scan_hit  = valid[idx] && (keys[idx] == key_q);
    scan_end  = scan_hit || (idx == IW'(DEPTH-1));
    slot_free = free_found || !valid[idx];
    put_idx   = (scan_hit || !free_found) ? idx : free_idx;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = (op_e'(req_op) == OP_CLEAR) ? RESP : SEARCH;
        end
      end
      SEARCH: begin
        if (scan_end) begin
          state_nx  = RESP;
          put_write = (op_q == OP_PUT) && (scan_hit || slot_free);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_PUT;
      key_q      <= '0;
      val_q      <= '0;
      idx        <= '0;
      free_idx   <= '0;
      free_found <= 1'b0;
      valid      <= '0;
      count_q    <= '0;
      status_q   <= ST_OK;
      rsp_val_q  <= '0;
    end else begin
      if (accept) begin
        op_q       <= op_e'(req_op);
        key_q      <= req_key;
        val_q      <= req_val;
        idx        <= '0;
        free_found <= 1'b0;
        rsp_val_q  <= '0;
        if (op_e'(req_op) == OP_CLEAR) begin
`ifdef KV_TABLE_CLEAR_EN
          valid    <= '0;
          count_q  <= '0;
          status_q <= ST_OK;
`else
          status_q <= ST_BAD_OP;
`endif
        end
      end
      if (state == SEARCH) begin
        if (scan_end) begin
          case (op_q)
            OP_PUT: begin
              if (scan_hit) status_q <= ST_OK;
              else if (slot_free) begin
                valid[put_idx] <= 1'b1;
                count_q        <= count_q + CW'(1);
                status_q       <= ST_OK;
              end else status_q <= ST_FULL;
            end
            OP_GET: begin
              if (scan_hit) begin
                status_q  <= ST_OK;
                rsp_val_q <= vals[idx];
              end else status_q <= ST_NOT_FOUND;
            end
            OP_DEL: begin
              if (scan_hit) begin
                valid[idx] <= 1'b0;
                count_q    <= count_q - CW'(1);
                status_q   <= ST_OK;
              end else status_q <= ST_NOT_FOUND;
            end
            default: status_q <= ST_BAD_OP;
          endcase
        end else begin
          idx <= idx + IW'(1);
          if (!free_found && !valid[idx]) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
        end
      end
    end
  end

  // Key/value storage carries no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (put_write) begin
      keys[put_idx] <= key_q;
      vals[put_idx] <= val_q;
    end
  end

  assign rsp_status = status_q;
  assign rsp_val    = rsp_val_q;
  assign count      = count_q;

endmodule
